e_mdu: RTL and testbench

- Multiply/divide unit in the E stage, beside the ALU; fed the same forwarded operands (in1 = rs, in2 = rt) from the D/E pipeline register.
- Owns the HI/LO registers and models multi-cycle latency with a busy counter.
- Hazard unit stalls D while (start | busy) and an MD-class instruction sits in D.
- MDUout feeds the E/M register for mfhi/mflo.

---
 rtl/e_mdu_pkg.sv | 32 +++
 rtl/e_mdu.sv | 174 +++++++++++++++++
 tb/tb_e_mdu.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared constants for the E-stage multiply/divide unit.
//   DATA_W           operand / HI / LO width
//   MDU_* codes      MDUcon operation encodings (madd family codes are
//                    reserved even when MDU_MADD_EN is not defined)
//   MDU_*_CYCLES     default busy-cycle counts
//   mdu_res_t        {hi, lo} result pair
package e_mdu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] MDU_mult  = 4'd1;
  localparam logic [3:0] MDU_multu = 4'd2;
  localparam logic [3:0] MDU_div   = 4'd3;
  localparam logic [3:0] MDU_divu  = 4'd4;
  localparam logic [3:0] MDU_mfhi  = 4'd5;
  localparam logic [3:0] MDU_mflo  = 4'd6;
  localparam logic [3:0] MDU_mthi  = 4'd7;
  localparam logic [3:0] MDU_mtlo  = 4'd8;
  localparam logic [3:0] MDU_madd  = 4'd9;
  localparam logic [3:0] MDU_maddu = 4'd10;
  localparam logic [3:0] MDU_msub  = 4'd11;
  localparam logic [3:0] MDU_msubu = 4'd12;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } mdu_res_t;

endpackage

// File: rtl/e_mdu.sv
// e_mdu: multiply/divide unit in the E stage. Owns HI/LO; the result is
// computed when the op launches, held in shadow registers, and committed
// to HI/LO when the busy counter expires.
//   clk     pipeline clock
//   reset   asynchronous active-low reset, clears all state
//   in1     operand A (rs)
//   in2     operand B (rt)
//   MDUcon  operation code (e_mdu_pkg)
//   start   launch MDUcon this cycle
//   busy    operation in flight
//   HI, LO  architectural HI/LO registers
//   MDUout  HI for mfhi, LO for mflo, else 0 (combinational)
// Build option: define MDU_MADD_EN to add madd/maddu/msub/msubu.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [3:0]        MDUcon,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic [DATA_W-1:0] MDUout
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] s_hi;
  logic [DATA_W-1:0] s_lo;
  mdu_res_t          res_mul_s;
  mdu_res_t          res_mul_u;

  function automatic mdu_res_t mul_s(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ae;
    logic signed [2*DATA_W-1:0] be;
    ae = a;
    be = b;
    return mdu_res_t'(ae * be);
  endfunction

  function automatic mdu_res_t mul_u(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b);
    return mdu_res_t'({{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b});
  endfunction

  // Caller guarantees b != 0. The one overflowing case (most negative / -1)
  // is pinned to quotient = dividend, remainder = 0.
  function automatic mdu_res_t div_s(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b);
    mdu_res_t r;
    if (a == {1'b1, {(DATA_W-1){1'b0}}} && b == '1) begin
      r.hi = '0;
      r.lo = a;
    end else begin
      r.hi = a % b;
      r.lo = a / b;
    end
    return r;
  endfunction

  function automatic mdu_res_t div_u(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b);
    mdu_res_t r;
    r.hi = a % b;
    r.lo = a / b;
    return r;
  endfunction

  // 64-bit wrap-around accumulate of a product into the current {HI,LO}.
  function automatic mdu_res_t acc(input mdu_res_t cur, input mdu_res_t p,
                                   input logic sub);
    return sub ? mdu_res_t'(cur - p) : mdu_res_t'(cur + p);
  endfunction

  assign res_mul_s = mul_s(in1, in2);
  assign res_mul_u = mul_u(in1, in2);
  assign busy      = (state == ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
      s_hi  <= '0;
      s_lo  <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        case (MDUcon)
          MDU_mult: begin
            {s_hi, s_lo} <= res_mul_s;
            cnt          <= CNT_W'(MULT_CYCLES);
            state        <= ST_RUN;
          end
          MDU_multu: begin
            {s_hi, s_lo} <= res_mul_u;
            cnt          <= CNT_W'(MULT_CYCLES);
            state        <= ST_RUN;
          end
          // Divide by zero still occupies the unit; the shadow copies the
          // current HI/LO so the commit leaves them unchanged.
          MDU_div: begin
            {s_hi, s_lo} <= (in2 == '0) ? {HI, LO} : div_s(in1, in2);
            cnt          <= CNT_W'(DIV_CYCLES);
            state        <= ST_RUN;
          end
          MDU_divu: begin
            {s_hi, s_lo} <= (in2 == '0) ? {HI, LO} : div_u(in1, in2);
            cnt          <= CNT_W'(DIV_CYCLES);
            state        <= ST_RUN;
          end
`ifdef MDU_MADD_EN
          MDU_madd: begin
            {s_hi, s_lo} <= acc({HI, LO}, res_mul_s, 1'b0);
            cnt          <= CNT_W'(MULT_CYCLES);
            state        <= ST_RUN;
          end
          MDU_maddu: begin
            {s_hi, s_lo} <= acc({HI, LO}, res_mul_u, 1'b0);
            cnt          <= CNT_W'(MULT_CYCLES);
            state        <= ST_RUN;
          end
          MDU_msub: begin
            {s_hi, s_lo} <= acc({HI, LO}, res_mul_s, 1'b1);
            cnt          <= CNT_W'(MULT_CYCLES);
            state        <= ST_RUN;
          end
          MDU_msubu: begin
            {s_hi, s_lo} <= acc({HI, LO}, res_mul_u, 1'b1);
            cnt          <= CNT_W'(MULT_CYCLES);
            state        <= ST_RUN;
          end
`endif
          MDU_mthi: HI <= in1;
          MDU_mtlo: LO <= in1;
          default: ;
        endcase
      end
    end else begin
      // RUN: start is ignored; commit on the last counted edge.
      if (cnt == CNT_W'(1)) begin
        HI    <= s_hi;
        LO    <= s_lo;
        cnt   <= '0;
        state <= ST_IDLE;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    MDUout = '0;
    case (MDUcon)
      MDU_mfhi: MDUout = HI;
      MDU_mflo: MDUout = LO;
      default:  MDUout = '0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: self-checking bench for e_mdu. A transaction-level model tracks
// HI/LO and the pending result as an absolute completion cycle number.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [3:0]  MDUcon;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUout;

  e_mdu dut (
    .clk    (clk),
    .reset  (reset),
    .in1    (in1),
    .in2    (in2),
    .MDUcon (MDUcon),
    .start  (start),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO),
    .MDUout (MDUout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          cyc    = 0;
  logic [31:0] m_hi   = 0;
  logic [31:0] m_lo   = 0;
  bit          m_pend = 0;
  int          m_done = 0;
  logic [31:0] m_phi  = 0;
  logic [31:0] m_plo  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic launch(input logic [63:0] res, input int n);
    m_phi  = res[63:32];
    m_plo  = res[31:0];
    m_done = cyc + n;
    m_pend = 1;
  endtask

  // Applies the inputs seen at this clock edge to the model.
  task automatic model_edge();
    bit          idle;
    logic [63:0] ps;
    logic [63:0] pu;
    int          qi;
    int          ri;
    idle = !m_pend;
    if (m_pend && cyc == m_done) begin
      m_hi   = m_phi;
      m_lo   = m_plo;
      m_pend = 0;
    end
    ps = longint'(signed'(in1)) * longint'(signed'(in2));
    pu = longint'({32'b0, in1}) * longint'({32'b0, in2});
    if (idle && start) begin
      case (MDUcon)
        MDU_mult:  launch(ps, 5);
        MDU_multu: launch(pu, 5);
        MDU_div: begin
          if (in2 == 0) launch({m_hi, m_lo}, 10);
          else begin
            qi = signed'(in1) / signed'(in2);
            ri = signed'(in1) % signed'(in2);
            launch({ri, qi}, 10);
          end
        end
        MDU_divu: begin
          if (in2 == 0) launch({m_hi, m_lo}, 10);
          else launch({in1 % in2, in1 / in2}, 10);
        end
`ifdef MDU_MADD_EN
        MDU_madd:  launch({m_hi, m_lo} + ps, 5);
        MDU_maddu: launch({m_hi, m_lo} + pu, 5);
        MDU_msub:  launch({m_hi, m_lo} - ps, 5);
        MDU_msubu: launch({m_hi, m_lo} - pu, 5);
`endif
        MDU_mthi: m_hi = in1;
        MDU_mtlo: m_lo = in1;
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_pend = 0; m_phi = 0; m_plo = 0;
  endtask

  task automatic step();
    logic [31:0] exp_out;
    @(posedge clk);
    cyc++;
    if (reset) model_edge();
    #1;
    exp_out = (MDUcon == MDU_mfhi) ? m_hi : (MDUcon == MDU_mflo) ? m_lo : 32'h0;
    chk("busy", {31'b0, busy}, {31'b0, m_pend});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
    chk("MDUout", MDUout, exp_out);
  endtask

  task automatic op(input logic [3:0] con, input logic [31:0] a, input logic [31:0] b);
    MDUcon = con; in1 = a; in2 = b; start = 1'b1;
    step();
    start = 1'b0; MDUcon = 4'd0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) step();
    chk("idle_wait", {31'b0, busy}, 32'h0);
  endtask

  task automatic read_back(input logic [31:0] eh, input logic [31:0] el, input string tag);
    MDUcon = MDU_mfhi; #1;
    chk({tag, "_mfhi"}, MDUout, eh);
    MDUcon = MDU_mflo; #1;
    chk({tag, "_mflo"}, MDUout, el);
    MDUcon = 4'd0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    reset = 1'b0; in1 = 0; in2 = 0; MDUcon = 0; start = 0;
    step();
    step();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    #2 reset = 1'b1;
    step();

    // mult -2 * 3
    op(MDU_mult, 32'hFFFFFFFE, 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("mult_busy_hold", {31'b0, busy}, 32'h1);
      step();
    end
    chk("mult_busy_last", {31'b0, busy}, 32'h1);
    step();
    chk("mult_busy_drop", {31'b0, busy}, 32'h0);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);

    // divu 7 / 2
    op(MDU_divu, 32'd7, 32'd2);
    for (int i = 0; i < 9; i++) step();
    chk("divu_busy_last", {31'b0, busy}, 32'h1);
    step();
    chk("divu_busy_drop", {31'b0, busy}, 32'h0);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    // div -7 / 2
    op(MDU_div, 32'hFFFFFFF9, 32'd2);
    wait_idle();
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    // divide by zero keeps HI/LO
    op(MDU_mthi, 32'h1234, 32'h0);
    op(MDU_mtlo, 32'h5678, 32'h0);
    op(MDU_div, 32'd5, 32'd0);
    for (int i = 0; i < 9; i++) step();
    chk("div0_busy_last", {31'b0, busy}, 32'h1);
    step();
    chk("div0_busy_drop", {31'b0, busy}, 32'h0);
    read_back(32'h1234, 32'h5678, "div0");

    // start while busy is ignored
    op(MDU_divu, 32'd100, 32'd7);
    step();
    op(MDU_multu, 32'd5, 32'd6);
    op(MDU_mthi, 32'hDEAD, 32'h0);
    wait_idle();
    chk("ign_hi", HI, 32'd2);
    chk("ign_lo", LO, 32'd14);

    // asynchronous reset mid-run
    op(MDU_mult, 32'd3, 32'd4);
    step();
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_hi", HI, 32'h0);
    chk("arst_lo", LO, 32'h0);
    model_reset();
    step();
    #2 reset = 1'b1;
    step();
    step();
    step();

    // maddu accumulate (or no effect without the option)
    op(MDU_mthi, 32'h0, 32'h0);
    op(MDU_mtlo, 32'hFFFFFFFF, 32'h0);
    op(MDU_maddu, 32'd1, 32'd1);
    wait_idle();
`ifdef MDU_MADD_EN
    chk("maddu_hi", HI, 32'h1);
    chk("maddu_lo", LO, 32'h0);
`else
    chk("maddu_hi", HI, 32'h0);
    chk("maddu_lo", LO, 32'hFFFFFFFF);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      MDUcon = 4'($urandom_range(0, 15));
      in1 = a;
      in2 = b;
      start = ($urandom_range(0, 3) != 0);
      step();
    end
    start = 1'b0; MDUcon = 4'd0;
    wait_idle();
    read_back(m_hi, m_lo, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
